// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency single-word backing-memory responder
//
// Target end of the cache-to-RAM request interface. A request (req with
// rw/addr/wdata) is accepted in IDLE or in the one-cycle DONE state, waits
// `latency` edges, then performs the access and pulses done for one cycle.
// Out-of-range addresses (addr >= depth) discard writes and read as zero.
//
// Optional feature macro: MEM_STATS_EN (adds saturating rd_count/wr_count).
//
// Ports:
//   clk          system clock, all logic on posedge
//   clr          synchronous reset, active-high, clears state and all words
//   req          request strobe, sampled when accepting
//   rw           0 = read, 1 = write, sampled with req
//   addr         word address, sampled with req
//   wdata        write data, sampled with req
//   busy         high from acceptance edge until done falls
//   done         one-cycle completion pulse
//   rdata        read result, held until the next completed read
//   state        FSM state: 0 IDLE, 1 WAIT, 2 DONE
//   mem0..mem7   contents of words 0..7
//   rd_count     (MEM_STATS_EN) completed reads, saturating
//   wr_count     (MEM_STATS_EN) completed writes, saturating

module mem_responder #(
  parameter int d_width = 8,
  parameter int a_width = 8,
  parameter int depth   = 256,
  parameter int latency = 3
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               req,
  input  logic               rw,
  input  logic [a_width-1:0] addr,
  input  logic [d_width-1:0] wdata,
  output logic               busy,
  output logic               done,
  output logic [d_width-1:0] rdata,
  output logic [1:0]         state,
  output logic [d_width-1:0] mem0,
  output logic [d_width-1:0] mem1,
  output logic [d_width-1:0] mem2,
  output logic [d_width-1:0] mem3,
  output logic [d_width-1:0] mem4,
  output logic [d_width-1:0] mem5,
  output logic [d_width-1:0] mem6,
  output logic [d_width-1:0] mem7
`ifdef MEM_STATS_EN
  ,
  output logic [15:0]        rd_count,
  output logic [15:0]        wr_count
`endif
);

  localparam int IW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = (latency > 1) ? $clog2(latency) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               rw_q, rw_d;
  logic [a_width-1:0] addr_q, addr_d;
  logic [d_width-1:0] wdata_q, wdata_d;
  logic [d_width-1:0] rdata_q;
  logic [d_width-1:0] mem_q [depth];
  logic               accept;
  logic               access;
  logic               in_range;
  logic [IW-1:0]      idx;

  assign in_range = (32'(addr_q) < 32'(depth));
  assign idx      = addr_q[IW-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    accept  = 1'b0;
    access  = 1'b0;
    case (state_q)
      S_IDLE: accept = req;
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          access  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // A request arriving in the DONE cycle is taken directly so busy
        // never drops between back-to-back transactions.
        if (req) accept = 1'b1;
        else     state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      rw_d    = rw;
      addr_d  = addr;
      wdata_d = wdata;
      cnt_d   = CW'(latency - 1);
      state_d = S_WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < depth; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else if (access) begin
      if (rw_q) begin
        if (in_range) mem_q[idx] <= wdata_q;
      end else begin
        rdata_q <= in_range ? mem_q[idx] : '0;
      end
    end
  end

`ifdef MEM_STATS_EN
  logic [15:0] rd_count_q, wr_count_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else if (access) begin
      if (rw_q && wr_count_q != 16'hFFFF)  wr_count_q <= wr_count_q + 16'd1;
      if (!rw_q && rd_count_q != 16'hFFFF) rd_count_q <= rd_count_q + 16'd1;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);
  assign state = state_q;
  assign rdata = rdata_q;
  assign mem0  = mem_q[0];
  assign mem1  = mem_q[1];
  assign mem2  = mem_q[2];
  assign mem3  = mem_q[3];
  assign mem4  = mem_q[4];
  assign mem5  = mem_q[5];
  assign mem6  = mem_q[6];
  assign mem7  = mem_q[7];

endmodule
